// File: rtl/match_count_display_if.sv
// match_count_display_if: detector count and clear button in, seven-segment pins out.
interface match_count_display_if;
   logic [3:0] n_in;
   logic       peak_clr;
   logic [6:0] seg;
   logic [3:0] an;
   logic       dp;
   modport master (output n_in, peak_clr, input seg, an, dp);
   modport slave (input n_in, peak_clr, output seg, an, dp);
endinterface

// File: rtl/match_count_display.sv
// match_count_display: shows current and peak match count as two decimal pairs on a
// 4-digit multiplexed seven-segment display (current on the right, peak on the left).
module match_count_display #(
   parameter int REFRESH_DIV = 50000
) (
   input logic clk,
   input logic rst_n,
   match_count_display_if.slave bus
);
   localparam int CW = $clog2(REFRESH_DIV);
   logic [3:0] n_q, n_d, peak_q, peak_d;
   logic [2:0] sync_q, sync_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0] idx_q, idx_d;
   logic [6:0] seg_q, seg_d;
   logic [3:0] an_q, an_d;
   logic dp_q, dp_d;
   logic clr_pulse, tc, cur_t, pk_t, blank;
   logic [3:0] cur_u, pk_u, sel;

   function automatic logic [6:0] glyph(input logic [3:0] v);
      case (v)
         4'd0: glyph = 7'b1000000;
         4'd1: glyph = 7'b1111001;
         4'd2: glyph = 7'b0100100;
         4'd3: glyph = 7'b0110000;
         4'd4: glyph = 7'b0011001;
         4'd5: glyph = 7'b0010010;
         4'd6: glyph = 7'b0000010;
         4'd7: glyph = 7'b1111000;
         4'd8: glyph = 7'b0000000;
         4'd9: glyph = 7'b0010000;
         default: glyph = 7'b1111111;
      endcase
   endfunction

   // sync_q[1:0] synchronise the button, sync_q[2] is the previous level for edge detect
   always_comb begin
      clr_pulse = sync_q[1] & ~sync_q[2];
      sync_d = {sync_q[1:0], bus.peak_clr};
      n_d = bus.n_in;
      peak_d = clr_pulse ? 4'd0 : (n_q > peak_q) ? n_q : peak_q;
      tc = cnt_q == CW'(REFRESH_DIV - 1);
      cnt_d = tc ? '0 : cnt_q + 1'b1;
      idx_d = tc ? idx_q + 2'd1 : idx_q;
      cur_t = n_q >= 4'd10;
      pk_t = peak_q >= 4'd10;
      cur_u = cur_t ? n_q - 4'd10 : n_q;
      pk_u = pk_t ? peak_q - 4'd10 : peak_q;
      sel = idx_q[1] ? (idx_q[0] ? {3'b000, pk_t} : pk_u) : (idx_q[0] ? {3'b000, cur_t} : cur_u);
      blank = idx_q[0] && sel == 4'd0;
      seg_d = blank ? 7'b1111111 : glyph(sel);
      an_d = ~(4'b0001 << idx_q);
      dp_d = idx_q != 2'd2;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_q <= '0;
         peak_q <= '0;
         sync_q <= '0;
         cnt_q <= '0;
         idx_q <= '0;
         seg_q <= 7'b1111111;
         an_q <= 4'b1111;
         dp_q <= 1'b1;
      end else begin
         n_q <= n_d;
         peak_q <= peak_d;
         sync_q <= sync_d;
         cnt_q <= cnt_d;
         idx_q <= idx_d;
         seg_q <= seg_d;
         an_q <= an_d;
         dp_q <= dp_d;
      end
   end

   assign bus.seg = seg_q;
   assign bus.an = an_q;
   assign bus.dp = dp_q;
endmodule

// File: tb/tb_match_count_display.sv
// tb_match_count_display: table vectors, history-based display model with random
// counts, and hand-timed peak-clear and mid-scan reset sequences.
module tb_match_count_display;
   localparam int R = 4;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   match_count_display_if bus();
   match_count_display #(.REFRESH_DIV(R)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] n;
      logic [6:0] s0, s1, s2, s3;
   } vec_t;
   vec_t tv [6];
   int nvec = 0;
   int nerr = 0;
   int hist [0:511];
   logic [6:0] gl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, exp);
      end
   endtask

   task automatic wait_an(input logic [3:0] a);
      for (int k = 0; k < 40; k++) begin
         step();
         if (bus.an === a) return;
      end
      chk("wait_an_timeout", 32'(bus.an), 32'(a));
   endtask

   // digit d of the display given current value cur and peak value pk
   function automatic logic [6:0] digit_seg(input int d, input int cur, input int pk);
      int v;
      v = (d < 2) ? cur : pk;
      if (d % 2 == 1) return (v / 10 == 0) ? 7'b1111111 : gl[v / 10];
      return gl[v % 10];
   endfunction

   function automatic int next_val(input int e, input int mode);
      if (mode == 1) return (e <= 16) ? 5 : (e <= 32) ? 12 : 3;
      return ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : hist[e - 1];
   endfunction

   // hist[e] is the n_in value present at edge e after release; the display after
   // edge t shows hist[t-1] as current and max(hist[1..t-2]) as peak
   task automatic model_run(input int n, input int mode);
      hist[0] = 0;
      hist[1] = next_val(1, mode);
      @(posedge clk);
      #1;
      bus.n_in = 4'(hist[1]);
      rst_n = 1'b1;
      for (int t = 1; t <= n; t++) begin
         int d, pk;
         logic [3:0] ea;
         logic edp;
         step();
         d = ((t - 1) / R) % 4;
         pk = 0;
         for (int i = 1; i <= t - 2; i++) if (hist[i] > pk) pk = hist[i];
         ea = ~(4'b0001 << d);
         edp = (d != 2);
         chk("scan_an", 32'(bus.an), 32'(ea));
         chk("scan_dp", 32'(bus.dp), 32'(edp));
         chk("scan_seg", 32'(bus.seg), 32'(digit_seg(d, hist[t - 1], pk)));
         hist[t + 1] = next_val(t + 1, mode);
         bus.n_in = 4'(hist[t + 1]);
      end
   endtask

   initial begin
      tv[0] = '{4'd9,  7'b0010000, 7'b1111111, 7'b0010000, 7'b1111111};
      tv[1] = '{4'd13, 7'b0110000, 7'b1111001, 7'b0110000, 7'b1111001};
      tv[2] = '{4'd0,  7'b1000000, 7'b1111111, 7'b1000000, 7'b1111111};
      tv[3] = '{4'd15, 7'b0010010, 7'b1111001, 7'b0010010, 7'b1111001};
      tv[4] = '{4'd10, 7'b1000000, 7'b1111001, 7'b1000000, 7'b1111001};
      tv[5] = '{4'd7,  7'b1111000, 7'b1111111, 7'b1111000, 7'b1111111};
      bus.n_in = 4'd0;
      bus.peak_clr = 1'b0;
      repeat (3) step();
      chk("rst_an", 32'(bus.an), 32'h0000000f);
      chk("rst_seg", 32'(bus.seg), 32'h0000007f);
      chk("rst_dp", 32'(bus.dp), 32'h1);
      foreach (tv[i]) begin
         rst_n = 1'b0;
         bus.n_in = tv[i].n;
         step();
         step();
         rst_n = 1'b1;
         repeat (40) step();
         for (int k = 0; k < 16; k++) begin
            logic [6:0] es;
            logic edp;
            step();
            es = (bus.an == 4'b1110) ? tv[i].s0 : (bus.an == 4'b1101) ? tv[i].s1 :
                 (bus.an == 4'b1011) ? tv[i].s2 : (bus.an == 4'b0111) ? tv[i].s3 : 7'bxxxxxxx;
            edp = (bus.an != 4'b1011);
            chk("tab_seg", 32'(bus.seg), 32'(es));
            chk("tab_dp", 32'(bus.dp), 32'(edp));
         end
      end
      // peak hold: 5, 12, 3 each for one full scan
      rst_n = 1'b0;
      step();
      model_run(56, 1);
      // peak clear: press lands so the peak-units digit shows 12 -> 0 -> 3
      wait_an(4'b1110);
      wait_an(4'b1101);
      step();
      bus.peak_clr = 1'b1;
      repeat (3) step();
      chk("clr_an", 32'(bus.an), 32'h0000000b);
      chk("clr_pk12", 32'(bus.seg), 32'b0100100);
      step();
      chk("clr_pk0", 32'(bus.seg), 32'b1000000);
      step();
      chk("clr_pk3a", 32'(bus.seg), 32'b0110000);
      step();
      chk("clr_pk3b", 32'(bus.seg), 32'b0110000);
      step();
      chk("clr_tens", 32'(bus.seg), 32'b1111111);
      repeat (4) step();
      bus.peak_clr = 1'b0;
      wait_an(4'b1110);
      chk("clr_cur", 32'(bus.seg), 32'b0110000);
      wait_an(4'b1011);
      chk("clr_hold", 32'(bus.seg), 32'b0110000);
      // mid-scan asynchronous reset
      step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_an", 32'(bus.an), 32'h0000000f);
      chk("mid_rst_seg", 32'(bus.seg), 32'h0000007f);
      chk("mid_rst_dp", 32'(bus.dp), 32'h1);
      model_run(200, 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
